mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit that owns and writes the architectural Hi/Lo registers.
- The ALU reads Hi/Lo for mfhi/mflo; this block is the writer side for mult, multu, div, divu, mthi and mtlo.
- Sits in the EX stage beside the ALU and takes the same forwarded rs/rt operands.
- Drives Busy so hazard logic can stall later md-class instructions while an operation is in flight.

---
 rtl/mult_div_unit_pkg.sv | 24 ++
 rtl/mult_div_unit_md_arith.sv | 61 ++++++
 rtl/mult_div_unit.sv | 101 ++++++++++
 tb/tb_mult_div_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MDOp encodings, the default latencies and the sequencer state type.
package mult_div_unit_pkg;

  // MDOp encodings; 3'b111 is unused and decodes as "no operation".
  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
// Ports:
//   i_op            MDOp encoding (only mult/multu/div/divu matter here)
//   i_a, i_b        rs / rt operands
//   o_result        {hi, lo}: product, or {remainder, quotient}
//   o_div_by_zero   high for div/divu with i_b == 0 (o_result is then 0)
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_b_zero;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_b_zero = (i_b == 32'd0);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign w_a_ext = {{32{w_signed & i_a[31]}}, i_a};
  assign w_b_ext = {{32{w_signed & i_b[31]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero and the
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_mag  = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_b_mag  = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
  assign w_b_safe = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_signed && (i_a[31] ^ i_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r      = (w_signed && i_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    o_result      = 64'd0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MD_MULT, MD_MULTU: o_result = w_prod;
      MD_DIV, MD_DIVU: begin
        o_div_by_zero = w_b_zero;
        o_result      = w_b_zero ? 64'd0 : {w_r, w_q};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit; sole writer of the architectural Hi/Lo registers.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   A1, A2      rs / rt operands (A1 is also the mthi/mtlo source)
//   MDOp        operation select (see mult_div_unit_pkg::md_op_e)
//   Hi, Lo      architectural Hi/Lo registers
//   Busy        high while a mult/div is in flight
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [2:0]  MDOp,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy
);

  md_state_e   r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic [63:0] r_pend, w_pend_d;
  logic        r_dbz, w_dbz_d;

  logic [63:0] w_result;
  logic        w_div_by_zero;

  md_arith u_md_arith (
    .i_op          (MDOp),
    .i_a           (A1),
    .i_b           (A2),
    .o_result      (w_result),
    .o_div_by_zero (w_div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_pend  <= 64'd0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_pend  <= w_pend_d;
      r_dbz   <= w_dbz_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_pend_d  = r_pend;
    w_dbz_d   = r_dbz;
    case (r_state)
      StIdle: begin
        case (MDOp)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            w_pend_d  = w_result;
            w_dbz_d   = w_div_by_zero;
            w_cnt_d   = ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) ?
                        32'(MULT_CYCLES) : 32'(DIV_CYCLES);
            w_state_d = StRun;
          end
          MD_MTHI: w_hi_d = A1;
          MD_MTLO: w_lo_d = A1;
          default: ;
        endcase
      end
      StRun: begin
        // Any MDOp arriving here is dropped; stall logic upstream prevents it.
        w_cnt_d = r_cnt - 32'd1;
        if (r_cnt == 32'd1) begin
          w_state_d = StIdle;
          if (!r_dbz) begin
            w_hi_d = r_pend[63:32];
            w_lo_d = r_pend[31:0];
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign Hi   = r_hi;
  assign Lo   = r_lo;
  assign Busy = (r_state == StRun);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random mult/div traffic
// checked against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A1;
  logic [31:0] A2;
  logic [2:0]  MDOp;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  // Architectural state predicted by the model.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A1    (A1),
    .A2    (A2),
    .MDOp  (MDOp),
    .Hi    (Hi),
    .Lo    (Lo),
    .Busy  (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: what Hi/Lo become after op, and how many Busy cycles it takes.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    hi  = m_hi;
    lo  = m_lo;
    lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      MD_MULT: begin
        sq = sa * sb;
        p  = sq;
        hi = p[63:32];
        lo = p[31:0];
        lat = MULT_N;
      end
      MD_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
        lat = MULT_N;
      end
      MD_DIV: begin
        lat = DIV_N;
        if (b != 32'd0) begin
          sq = sa / sb;
          sr = sa % sb;
          p  = sq;
          lo = p[31:0];
          p  = sr;
          hi = p[31:0];
        end
      end
      MD_DIVU: begin
        lat = DIV_N;
        if (b != 32'd0) begin
          lo = a / b;
          hi = a % b;
        end
      end
      MD_MTHI: hi = a;
      MD_MTLO: lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDOp = op;
    A1   = a;
    A2   = b;
    @(posedge clk);
    #1;
    MDOp = MD_NONE;
    A1   = $urandom;
    A2   = $urandom;
  endtask

  // Run a mult/div end to end. inj > 0 drives inj_op on that Busy cycle, which must be ignored.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj, input logic [2:0] inj_op);
    logic [31:0] eh, el;
    int          lat;
    model(op, a, b, eh, el, lat);
    issue(op, a, b);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check({tag, " busy"}, {31'd0, Busy}, 32'd1);
      check({tag, " hi held"}, Hi, m_hi);
      check({tag, " lo held"}, Lo, m_lo);
      MDOp = (i == inj) ? inj_op : MD_NONE;
      A1   = 32'hDEAD_BEEF;
      A2   = 32'h0000_0003;
    end
    @(negedge clk);
    MDOp = MD_NONE;
    m_hi = eh;
    m_lo = el;
    check({tag, " busy done"}, {31'd0, Busy}, 32'd0);
    check({tag, " hi"}, Hi, m_hi);
    check({tag, " lo"}, Lo, m_lo);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] eh, el;
    int          lat;
    model(op, a, 32'd0, eh, el, lat);
    issue(op, a, $urandom);
    @(negedge clk);
    m_hi = eh;
    m_lo = el;
    check({tag, " busy"}, {31'd0, Busy}, 32'd0);
    check({tag, " hi"}, Hi, m_hi);
    check({tag, " lo"}, Lo, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1;
    MDOp  = MD_NONE;
    A1    = 32'd0;
    A2    = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset hi", Hi, 32'd0);
    check("reset lo", Lo, 32'd0);

    run_md("mult", MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0, MD_NONE);
    check("mult hi const", Hi, 32'hFFFF_FFFF);
    check("mult lo const", Lo, 32'hFFFF_FFFE);
    run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, MD_NONE);
    check("multu hi const", Hi, 32'h0000_0001);
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, MD_NONE);
    check("div lo const", Lo, 32'hFFFF_FFFD);
    check("div hi const", Hi, 32'hFFFF_FFFF);
    run_md("divu", MD_DIVU, 32'd7, 32'd2, 0, MD_NONE);
    check("divu lo const", Lo, 32'd3);
    check("divu hi const", Hi, 32'd1);

    run_mt("mthi", MD_MTHI, 32'h1234_5678);
    run_mt("mtlo", MD_MTLO, 32'hCAFE_BABE);
    check("mtlo hi kept", Hi, 32'h1234_5678);

    run_mt("pre hi", MD_MTHI, 32'h11);
    run_mt("pre lo", MD_MTLO, 32'h22);
    run_md("div0", MD_DIV, 32'd100, 32'd0, 0, MD_NONE);
    check("div0 hi kept", Hi, 32'h11);
    check("div0 lo kept", Lo, 32'h22);
    run_md("divu0", MD_DIVU, 32'd5, 32'd0, 4, MD_MTHI);

    run_md("div+inj", MD_DIV, 32'd100, 32'd7, 3, MD_MULT);
    run_md("mthi in run", MD_MULTU, 32'd9, 32'd9, 2, MD_MTHI);
    run_md("mtlo last", MD_DIVU, 32'd50, 32'd6, DIV_N, MD_MTLO);
    run_md("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, MD_NONE);
    check("ovf lo const", Lo, 32'h8000_0000);
    check("ovf hi const", Hi, 32'h0000_0000);

    for (int n = 0; n < 24; n++) begin
      op = 3'(1 + $urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 31);
      if ($urandom_range(0, 4) == 0) run_mt("rnd mthi", MD_MTHI, $urandom);
      run_md("rnd", op, a, b, 0, MD_NONE);
    end

    // Reset on the 2nd Busy cycle aborts the mult; no late commit.
    issue(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("pre-abort busy", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    check("abort busy", {31'd0, Busy}, 32'd0);
    check("abort hi", Hi, 32'd0);
    check("abort lo", Lo, 32'd0);
    repeat (MULT_N + 2) @(negedge clk);
    check("no late hi", Hi, 32'd0);
    check("no late lo", Lo, 32'd0);
    check("no late busy", {31'd0, Busy}, 32'd0);

    // Reset together with an op: the op is dropped.
    @(negedge clk);
    reset = 1'b1;
    MDOp  = MD_MTHI;
    A1    = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    MDOp  = MD_NONE;
    @(negedge clk);
    check("rst+op hi", Hi, 32'd0);
    check("rst+op busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    MDOp  = MD_DIVU;
    A1    = 32'd8;
    A2    = 32'd2;
    @(posedge clk);
    #1;
    reset = 1'b0;
    MDOp  = MD_NONE;
    @(negedge clk);
    check("rst+div busy", {31'd0, Busy}, 32'd0);
    repeat (DIV_N + 1) @(negedge clk);
    check("rst+div lo", Lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
